systolic_drain: RTL and testbench

Result-side consumer for `systolic_array`. It waits until every accumulator reports valid, then captures the whole result matrix in one cycle and acknowledges it with `z_yumi`. It then streams the elements out one per beat, in row-major order, on a single valid/ready port. It sits between the array's `z_o`/`z_valid_o`/`z_yumi_i` bundle and any downstream sink (memory writer, result FIFO, checker).

---
 rtl/systolic_pkg.sv | 13 +
 rtl/drain_index_ctr.sv | 65 ++++++
 rtl/systolic_drain.sv | 130 +++++++++++++
 tb/tb_systolic_drain.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// Shared types and slot-indexing helper for the systolic array and its drain.
package systolic_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } drain_state_e;

  function automatic int slot_idx(input int r, input int c, input int array_width_p);
    return r + c * array_width_p;
  endfunction

endpackage

// File: rtl/drain_index_ctr.sv
// Row/column wrap counter walking a result matrix in row-major order.
module drain_index_ctr
  import systolic_pkg::*;
#(
  parameter int cols_p  = 2,
  parameter int rows_p  = 2,
  parameter int row_w_p = (rows_p > 1) ? $clog2(rows_p) : 1,
  parameter int col_w_p = (cols_p > 1) ? $clog2(cols_p) : 1
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               inc_i,
  input  logic               clr_i,
  output logic [row_w_p-1:0] row_o,
  output logic [col_w_p-1:0] col_o,
  output logic               last_o
);

  localparam logic [row_w_p-1:0] ROW_LAST = row_w_p'(rows_p - 1);
  localparam logic [col_w_p-1:0] COL_LAST = col_w_p'(cols_p - 1);

  logic [row_w_p-1:0] row_q, row_d;
  logic [col_w_p-1:0] col_q, col_d;

  // Next index: clear wins over increment; column wraps carry into the row.
  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (clr_i) begin
      row_d = '0;
      col_d = '0;
    end else if (inc_i) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        if (row_q == ROW_LAST) begin
          row_d = '0;
        end else begin
          row_d = row_q + 1'b1;
        end
      end else begin
        row_d = row_q;
        col_d = col_q + 1'b1;
      end
    end else begin
      row_d = row_q;
      col_d = col_q;
    end
  end

  // Index registers.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  assign row_o  = row_q;
  assign col_o  = col_q;
  assign last_o = (row_q == ROW_LAST) && (col_q == COL_LAST);

endmodule

// File: rtl/systolic_drain.sv
// Captures a complete systolic-array result matrix in one cycle and streams
// its elements out in row-major order on a valid/ready port.
module systolic_drain
  import systolic_pkg::*;
#(
  parameter int width_p        = 32,
  parameter int array_width_p  = 2,
  parameter int array_height_p = 2,
  localparam int N_LP     = array_width_p * array_height_p,
  localparam int ROW_W_LP = (array_height_p > 1) ? $clog2(array_height_p) : 1,
  localparam int COL_W_LP = (array_width_p > 1) ? $clog2(array_width_p) : 1
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic [width_p*N_LP-1:0]   z_i,
  input  logic [N_LP-1:0]           z_valid_i,
  output logic [N_LP-1:0]           z_yumi_o,
  output logic [width_p-1:0]        data_o,
  output logic [ROW_W_LP-1:0]       row_o,
  output logic [COL_W_LP-1:0]       col_o,
  output logic                      last_o,
  output logic                      valid_o,
  input  logic                      ready_i
);

  localparam int IDX_W_LP = (N_LP > 1) ? $clog2(N_LP) : 1;

  if (array_height_p != array_width_p) begin : g_bad_shape
    $error("systolic_drain: array_height_p must equal array_width_p");
  end

  drain_state_e        state_q;
  logic                valid_q;
  logic [width_p-1:0]  buf_q [N_LP];

  logic                handshake_s;
  logic                last_s;
  logic                capture_s;
  logic [ROW_W_LP-1:0] row_s;
  logic [COL_W_LP-1:0] col_s;
  logic [IDX_W_LP-1:0] idx_s;

  assign handshake_s = valid_q & ready_i;

  // A new matrix may enter when idle or exactly as the final beat leaves.
  always_comb begin
    capture_s = 1'b0;
    if (((state_q == IDLE) || (handshake_s && last_s)) && (&z_valid_i) && !reset_i) begin
      capture_s = 1'b1;
    end else begin
      capture_s = 1'b0;
    end
  end

  assign z_yumi_o = {N_LP{capture_s}};

  drain_index_ctr #(
    .cols_p  (array_width_p),
    .rows_p  (array_height_p),
    .row_w_p (ROW_W_LP),
    .col_w_p (COL_W_LP)
  ) u_index_ctr (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .inc_i   (handshake_s),
    .clr_i   (capture_s),
    .row_o   (row_s),
    .col_o   (col_s),
    .last_o  (last_s)
  );

  // Drain FSM with registered stream valid.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (capture_s) begin
            state_q <= STREAM;
            valid_q <= 1'b1;
          end else begin
            state_q <= IDLE;
            valid_q <= 1'b0;
          end
        end
        STREAM: begin
          if (capture_s) begin
            state_q <= STREAM;
            valid_q <= 1'b1;
          end else if (handshake_s && last_s) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
          end else begin
            state_q <= STREAM;
            valid_q <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Result buffer: contents are don't-care until the first capture.
  always_ff @(posedge clk_i) begin
    if (capture_s) begin
      for (int s = 0; s < N_LP; s++) begin
        buf_q[s] <= z_i[s*width_p +: width_p];
      end
    end else begin
      for (int s = 0; s < N_LP; s++) begin
        buf_q[s] <= buf_q[s];
      end
    end
  end

  assign idx_s = IDX_W_LP'(slot_idx(int'(row_s), int'(col_s), array_width_p));

  // Gated by valid so the stream port reads zero while idle or in reset.
  assign data_o  = valid_q ? buf_q[idx_s] : '0;
  assign row_o   = row_s;
  assign col_o   = col_s;
  assign last_o  = valid_q & last_s;
  assign valid_o = valid_q;

endmodule

// File: tb/tb_systolic_drain.sv
// Directed, table-driven bench for systolic_drain (2x2, 32-bit elements).
module tb_systolic_drain;

  logic         clk;
  logic         reset;
  logic [127:0] z_i;
  logic [3:0]   z_valid;
  logic [3:0]   z_yumi;
  logic [31:0]  data;
  logic [0:0]   row;
  logic [0:0]   col;
  logic         last;
  logic         valid;
  logic         ready;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic [3:0][31:0] in_v;   // row-major: k = r*2 + c
    logic [3:0][31:0] exp_v;  // hand-computed hex of each beat
  } vec_t;

  vec_t vecs [3];

  systolic_drain #(
    .width_p        (32),
    .array_width_p  (2),
    .array_height_p (2)
  ) dut (
    .clk_i     (clk),
    .reset_i   (reset),
    .z_i       (z_i),
    .z_valid_i (z_valid),
    .z_yumi_o  (z_yumi),
    .data_o    (data),
    .row_o     (row),
    .col_o     (col),
    .last_o    (last),
    .valid_o   (valid),
    .ready_i   (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Slot s = r + c*2: slot0=(0,0) slot1=(1,0) slot2=(0,1) slot3=(1,1).
  function automatic logic [127:0] pack_z(input logic [3:0][31:0] m);
    return {m[3], m[1], m[2], m[0]};
  endfunction

  task automatic cyc(input logic rdy, input logic [3:0] zv, input logic [127:0] zin);
    @(posedge clk);
    #1;
    ready   = rdy;
    z_valid = zv;
    z_i     = zin;
    @(negedge clk);
  endtask

  task automatic chk_beat(input logic [3:0][31:0] exp_v, input int k);
    chk("valid", 32'(valid), 32'd1);
    chk("data", data, exp_v[k]);
    chk("row", 32'(row), 32'(k / 2));
    chk("col", 32'(col), 32'(k % 2));
    chk("last", 32'(last), 32'(k == 3));
  endtask

  task automatic cap(input logic [3:0][31:0] m);
    cyc(1'b0, 4'hF, pack_z(m));
    chk("cap_yumi", 32'(z_yumi), 32'h0000000F);
    chk("cap_valid", 32'(valid), 32'd0);
  endtask

  task automatic drain(input logic [3:0][31:0] exp_v, input logic [15:0] pat,
                       input int npat, output int cycles);
    int          k;
    logic        rdy;
    logic        prev_stall;
    logic [31:0] s_data;
    logic [2:0]  s_rcl;
    k = 0;
    prev_stall = 1'b0;
    s_data = 32'd0;
    s_rcl = 3'd0;
    cycles = 0;
    for (int c = 0; c < 40 && k < 4; c++) begin
      rdy = (c < npat) ? pat[c] : 1'b1;
      cyc(rdy, 4'h0, 128'd0);
      chk("drain_yumi", 32'(z_yumi), 32'd0);
      if (prev_stall) begin
        chk("hold_data", data, s_data);
        chk("hold_rcl", 32'({row, col, last}), 32'(s_rcl));
      end
      chk_beat(exp_v, k);
      s_data = data;
      s_rcl = {row, col, last};
      prev_stall = valid & ~rdy;
      if (valid && rdy) k++;
      cycles = c + 1;
    end
    if (k < 4) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain_timeout: got %0d beats expected 4", k);
    end
  endtask

  initial begin
    int n;

    vecs[0].in_v[0] = -32'sd2103;        vecs[0].exp_v[0] = 32'hFFFFF7C9;
    vecs[0].in_v[1] = -32'sd3707;        vecs[0].exp_v[1] = 32'hFFFFF185;
    vecs[0].in_v[2] = 32'sd21950;        vecs[0].exp_v[2] = 32'h000055BE;
    vecs[0].in_v[3] = 32'sd30;           vecs[0].exp_v[3] = 32'h0000001E;
    vecs[1].in_v[0] = 32'sd0;            vecs[1].exp_v[0] = 32'h00000000;
    vecs[1].in_v[1] = 32'sd1;            vecs[1].exp_v[1] = 32'h00000001;
    vecs[1].in_v[2] = -32'sd1;           vecs[1].exp_v[2] = 32'hFFFFFFFF;
    vecs[1].in_v[3] = 32'sd2147483647;   vecs[1].exp_v[3] = 32'h7FFFFFFF;
    vecs[2].in_v[0] = 32'sd12345;        vecs[2].exp_v[0] = 32'h00003039;
    vecs[2].in_v[1] = -32'sd100;         vecs[2].exp_v[1] = 32'hFFFFFF9C;
    vecs[2].in_v[2] = 32'sd65536;        vecs[2].exp_v[2] = 32'h00010000;
    vecs[2].in_v[3] = -32'sd2147483647;  vecs[2].exp_v[3] = 32'h80000001;

    reset   = 1'b1;
    z_valid = 4'h0;
    z_i     = 128'd0;
    ready   = 1'b0;

    // Reset with random inputs: everything stays zero.
    for (int i = 0; i < 10; i++) begin
      cyc(1'($urandom), 4'($urandom), {$urandom, $urandom, $urandom, $urandom});
      chk("rst_yumi", 32'(z_yumi), 32'd0);
      chk("rst_valid", 32'(valid), 32'd0);
      chk("rst_data", data, 32'd0);
      chk("rst_rcl", 32'({row, col, last}), 32'd0);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    z_valid = 4'h0;
    ready = 1'b0;
    @(negedge clk);
    chk("post_rst_valid", 32'(valid), 32'd0);
    chk("slot_idx", 32'(systolic_pkg::slot_idx(0, 1, 2)), 32'd2);

    // Table: full-rate drains.
    for (int i = 0; i < 3; i++) begin
      cap(vecs[i].in_v);
      drain(vecs[i].exp_v, 16'd0, 0, n);
      chk("throughput", 32'(n), 32'd4);
    end

    // Backpressure 1,0,0,1,0,1,1.
    cap(vecs[0].in_v);
    drain(vecs[0].exp_v, 16'b0000000001101001, 7, n);
    chk("bp_cycles", 32'(n), 32'd7);

    // Partial valid is ignored.
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, 4'b0111, pack_z(vecs[2].in_v));
      chk("partial_yumi", 32'(z_yumi), 32'd0);
      chk("partial_valid", 32'(valid), 32'd0);
    end
    cap(vecs[1].in_v);
    drain(vecs[1].exp_v, 16'd0, 0, n);

    // Back-to-back: next matrix offered on the last beat.
    cap(vecs[0].in_v);
    for (int k = 0; k < 4; k++) begin
      if (k == 3) cyc(1'b1, 4'hF, pack_z(vecs[2].in_v));
      else cyc(1'b1, 4'h0, 128'd0);
      chk("b2b_yumi", 32'(z_yumi), (k == 3) ? 32'h0000000F : 32'd0);
      chk_beat(vecs[0].exp_v, k);
    end
    for (int k = 0; k < 4; k++) begin
      cyc(1'b1, 4'h0, 128'd0);
      chk("b2b_yumi2", 32'(z_yumi), 32'd0);
      chk_beat(vecs[2].exp_v, k);
    end
    cyc(1'b0, 4'h0, 128'd0);
    chk("b2b_idle", 32'(valid), 32'd0);

    // Reset after two beats discards the matrix.
    cap(vecs[2].in_v);
    for (int k = 0; k < 2; k++) begin
      cyc(1'b1, 4'h0, 128'd0);
      chk_beat(vecs[2].exp_v, k);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    z_valid = 4'hF;
    ready = 1'b1;
    #1;
    chk("midrst_valid", 32'(valid), 32'd0);
    chk("midrst_yumi", 32'(z_yumi), 32'd0);
    chk("midrst_data", data, 32'd0);
    chk("midrst_rcl", 32'({row, col, last}), 32'd0);
    for (int i = 0; i < 2; i++) begin
      cyc(1'b1, 4'hF, pack_z(vecs[0].in_v));
      chk("midrst_hold_yumi", 32'(z_yumi), 32'd0);
      chk("midrst_hold_valid", 32'(valid), 32'd0);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    z_valid = 4'h0;
    @(negedge clk);
    chk("after_rst_idle", 32'(valid), 32'd0);
    cap(vecs[1].in_v);
    drain(vecs[1].exp_v, 16'd0, 0, n);
    chk("after_rst_cycles", 32'(n), 32'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
